// File: rtl/wb_write_buffer.sv
// Write-back buffer: queues evicted cache lines and drains them in FIFO order to memory.
// Optional macro WB_COALESCE_EN merges a request into the newest entry when addresses match.
module wb_write_buffer #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mem_busy,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_hit,
    output logic [DATA_W-1:0] lk_data,
    output logic [CNT_W-1:0]  count,
    output logic              ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_ram [DEPTH];
    logic [DATA_W-1:0] data_ram [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              lk_hit_q, lk_hit_d;
    logic [DATA_W-1:0] lk_data_q, lk_data_d;
    logic              ovf_q, ovf_d;

    logic              empty, full, pop, push_new, coalesce;
    logic [PTR_W-1:0]  newest;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign pop    = ~mem_busy & ~empty;
    assign newest = tail_q - PTR_W'(1);

`ifdef WB_COALESCE_EN
    // Merging into an entry that is leaving this cycle would lose the new data.
    assign coalesce = in_valid & ~empty & (addr_ram[newest] == in_addr)
                      & ~((count_q == CNT_W'(1)) & pop);
`else
    assign coalesce = 1'b0;
`endif

    assign in_ready = ~full | pop | coalesce;
    assign push_new = in_valid & in_ready & ~coalesce;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q | (in_valid & ~in_ready);

        if (pop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_ram[head_q];
            wr_data_d = data_ram[head_q];
            head_d    = head_q + PTR_W'(1);
        end
        if (push_new) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (push_new && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_new) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Lookup scans head..tail-1 oldest first so the newest match overrides.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        lk_hit_d  = 1'b0;
        lk_data_d = lk_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_ram[idx] == lk_addr)) begin
                lk_hit_d  = 1'b1;
                lk_data_d = data_ram[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            lk_hit_q  <= 1'b0;
            lk_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            lk_hit_q  <= lk_hit_d;
            lk_data_q <= lk_data_d;
            ovf_q     <= ovf_d;
        end
    end

    // Entry storage is deliberately not reset; occupancy is tracked by head/tail/count.
    always_ff @(posedge clk) begin
        if (push_new) begin
            addr_ram[tail_q] <= in_addr;
            data_ram[tail_q] <= in_data;
        end
        if (coalesce) begin
            data_ram[newest] <= in_data;
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign lk_hit      = lk_hit_q;
    assign lk_data     = lk_data_q;
    assign count       = count_q;
    assign ovf_err     = ovf_q;

endmodule
